// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer type and size encodings, the data
// width, and the state type used by the SRAM slave data-phase FSM.
package ahb_pkg;

  localparam int AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane enable decoder for a 32-bit AHB-Lite data bus.
// Ports:
//   size    : HSIZE of the transfer (000 byte, 001 half, 010 word, others = word)
//   addr_lo : byte offset within the word (HADDR[1:0])
//   strb    : one enable bit per byte lane, lane 0 = bits [7:0]
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb
);

  // Lane selection; half-words ignore addr_lo[0], reserved sizes write the whole word.
  always_comb begin
    strb = 4'b1111;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM with WAIT_STATES wait cycles
// inserted in every data phase. Drives H_ready_o=1 and H_rdata_o=0 whenever it
// does not own the data phase, so it can be AND/OR-combined with other slaves.
// Ports:
//   H_clk, H_rst          : clock, synchronous active-high reset
//   H_sel, H_addr,
//   H_trans, H_write,
//   H_size                : address-phase control (H_sel from the decoder)
//   H_wdata               : write data (data phase)
//   H_ready_in            : global HREADY of the bus
//   H_ready_o, H_rdata_o  : this slave's ready and read data
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter  int DEPTH       = 1024,
  parameter  int WAIT_STATES = 0,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              H_clk,
  input  logic              H_rst,
  input  logic              H_sel,
  input  logic [31:0]       H_addr,
  input  logic [1:0]        H_trans,
  input  logic              H_write,
  input  logic [2:0]        H_size,
  input  logic [AHB_DW-1:0] H_wdata,
  input  logic              H_ready_in,
  output logic              H_ready_o,
  output logic [AHB_DW-1:0] H_rdata_o
);

  localparam bit         HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0] WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_r;
  state_t              state_next_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_next_s;
  logic                capture_s;
  logic                accept_s;
  logic                ready_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [1:0]          addr_lo_r;
  logic [2:0]          size_r;
  logic                write_r;
  logic [3:0]          strb_s;
  logic [AHB_DW-1:0]   rdata_s;
  logic [AHB_DW-1:0]   mem_r [DEPTH];
  logic                unused_s;

  // Address bits above the array (aliasing) and HTRANS[0] carry no meaning here.
  assign unused_s = ^{H_trans[0], H_addr[31:ADDR_W+2]};

  assign accept_s = H_sel & H_trans[1] & H_ready_in;

  ahb_byte_strobe u_strobe (
    .size    (size_r),
    .addr_lo (addr_lo_r),
    .strb    (strb_s)
  );

  // Next-state logic; a new transfer may only start from IDLE or the completing DATA cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (accept_s) begin
          capture_s = 1'b1;
          if (HAS_WAIT) begin
            state_next_s = ST_WAIT;
            cnt_next_s   = WS_LOAD;
          end else begin
            state_next_s = ST_DATA;
            cnt_next_s   = 4'd0;
          end
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_DATA;
          cnt_next_s   = 4'd0;
        end else begin
          state_next_s = ST_WAIT;
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, wait counter and ready register; ready is low exactly while in WAIT.
  always_ff @(posedge H_clk) begin
    if (H_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s != ST_WAIT);
    end
  end

  // Address-phase capture of word index, byte offset, size and direction.
  always_ff @(posedge H_clk) begin
    if (H_rst) begin
      idx_r     <= {ADDR_W{1'b0}};
      addr_lo_r <= 2'b00;
      size_r    <= 3'b000;
      write_r   <= 1'b0;
    end else if (capture_s) begin
      idx_r     <= H_addr[ADDR_W+1:2];
      addr_lo_r <= H_addr[1:0];
      size_r    <= H_size;
      write_r   <= H_write;
    end
  end

  // SRAM write at the edge ending a write DATA cycle; the array itself is never reset.
  always_ff @(posedge H_clk) begin
    if (!H_rst && (state_r == ST_DATA) && write_r) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_s[i]) begin
          mem_r[idx_r][8*i +: 8] <= H_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is driven only in a read DATA cycle so the bus OR-mux sees zero otherwise.
  always_comb begin
    rdata_s = {AHB_DW{1'b0}};
    if ((state_r == ST_DATA) && !write_r) begin
      rdata_s = mem_r[idx_r];
    end else begin
      rdata_s = {AHB_DW{1'b0}};
    end
  end

  assign H_ready_o = ready_r;
  assign H_rdata_o = rdata_s;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: three slaves (WAIT_STATES 0, 2, 3; DEPTH 64), each
// driven by a small pipelined AHB master and checked against a word-array
// reference model with byte-lane merging done in plain arithmetic.
module tb_ahb_sram_slave;

  localparam int NDUT = 3;
  localparam int DEP  = 64;

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  logic        H_clk;
  logic        H_rst;
  logic        sel       [NDUT];
  logic [31:0] addr      [NDUT];
  logic [1:0]  trans     [NDUT];
  logic        wr        [NDUT];
  logic [2:0]  size      [NDUT];
  logic [31:0] wdata     [NDUT];
  logic        force_low [NDUT];
  logic        ready_in  [NDUT];
  logic        ready_o   [NDUT];
  logic [31:0] rdata     [NDUT];

  logic [31:0] model_mem [NDUT][DEP];
  xfer_t       q[$];
  logic [31:0] last_rdata;
  int          total;
  int          bad;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign ready_in[g] = ready_o[g] & ~force_low[g];
    ahb_sram_slave #(.DEPTH(DEP), .WAIT_STATES((g == 0) ? 0 : g + 1)) u_dut (
      .H_clk      (H_clk),
      .H_rst      (H_rst),
      .H_sel      (sel[g]),
      .H_addr     (addr[g]),
      .H_trans    (trans[g]),
      .H_write    (wr[g]),
      .H_size     (size[g]),
      .H_wdata    (wdata[g]),
      .H_ready_in (ready_in[g]),
      .H_ready_o  (ready_o[g]),
      .H_rdata_o  (rdata[g])
    );
  end

  initial H_clk = 1'b0;
  always #5 H_clk = ~H_clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEP));
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference write: a byte lane b is covered if it is the addressed byte,
  // lies in the addressed half-word, or the size is word/reserved.
  task automatic mdl_write(input int d, input xfer_t x);
    int w;
    int a;
    bit hit;
    w = widx(x.addr);
    a = int'(x.addr % 32'd4);
    for (int b = 0; b < 4; b++) begin
      if (x.size == 3'd0)      hit = (b == a);
      else if (x.size == 3'd1) hit = ((b / 2) == (a / 2));
      else                     hit = 1'b1;
      if (hit) model_mem[d][w][8*b +: 8] = x.data[8*b +: 8];
    end
  endtask

  task automatic drive_idle(input int d);
    sel[d]   = 1'b0;
    trans[d] = 2'b00;
    addr[d]  = 32'h0;
    wr[d]    = 1'b0;
    size[d]  = 3'd0;
    wdata[d] = 32'h0;
  endtask

  // Pipelined master: starts and ends at posedge+1, runs every queued transfer on DUT d.
  task automatic run_queue(input int d, input int gap_pct);
    xfer_t ap;
    xfer_t dp;
    bit    have_ap;
    bit    have_dp;
    int    waits;
    int    budget;
    have_ap = 1'b0;
    have_dp = 1'b0;
    waits   = 0;
    budget  = 0;
    if (q.size() > 0) begin
      ap = q.pop_front();
      have_ap = 1'b1;
    end
    while ((have_ap || have_dp || q.size() > 0) && budget < 5000) begin
      if (have_ap) begin
        sel[d]   = 1'b1;
        trans[d] = ($urandom % 2 == 0) ? 2'b10 : 2'b11;
        addr[d]  = ap.addr;
        wr[d]    = ap.w;
        size[d]  = ap.size;
      end else begin
        case ($urandom % 3)
          0:       begin sel[d] = 1'b1; trans[d] = 2'b01; end
          1:       begin sel[d] = 1'b0; trans[d] = 2'b10; end
          default: begin sel[d] = 1'($urandom % 2); trans[d] = 2'b00; end
        endcase
        addr[d] = $urandom;
        wr[d]   = 1'($urandom % 2);
        size[d] = 3'($urandom % 8);
      end
      wdata[d] = (have_dp && dp.w) ? dp.data : $urandom;
      @(negedge H_clk);
      if (have_dp) begin
        if (ready_o[d]) begin
          chk_eq("wait_count", waits, ws_of(d));
          if (dp.w) begin
            chk_eq("rdata_on_write", rdata[d], 32'h0);
            mdl_write(d, dp);
          end else begin
            last_rdata = rdata[d];
            chk_eq("read_data", rdata[d], model_mem[d][widx(dp.addr)]);
          end
        end else begin
          chk_eq("rdata_in_wait", rdata[d], 32'h0);
          waits++;
        end
      end else begin
        chk_eq("idle_ready", {31'h0, ready_o[d]}, 32'h1);
        chk_eq("idle_rdata", rdata[d], 32'h0);
      end
      if (ready_o[d]) begin
        have_dp = have_ap;
        dp      = ap;
        waits   = 0;
        if (q.size() > 0 && ($urandom % 100) >= gap_pct) begin
          ap = q.pop_front();
          have_ap = 1'b1;
        end else begin
          have_ap = 1'b0;
        end
      end
      @(posedge H_clk);
      #1;
      budget++;
    end
    if (budget >= 5000) chk_eq("queue_budget", 32'h0, 32'h1);
    drive_idle(d);
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] dat);
    xfer_t x;
    x.addr = a;
    x.w    = w;
    x.size = s;
    x.data = dat;
    q.push_back(x);
  endtask

  // Two-cycle reset, then reset-state checks on every DUT; ends at posedge+1.
  task automatic do_reset();
    H_rst = 1'b1;
    repeat (2) begin
      @(posedge H_clk);
      #1;
    end
    H_rst = 1'b0;
    @(negedge H_clk);
    for (int d = 0; d < NDUT; d++) begin
      chk_eq("reset_ready", {31'h0, ready_o[d]}, 32'h1);
      chk_eq("reset_rdata", rdata[d], 32'h0);
    end
    @(posedge H_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    last_rdata = 32'h0;
    H_rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      force_low[d] = 1'b0;
      drive_idle(d);
    end
    #1;
    do_reset();

    // Preload every word, reset, and confirm the array survived the reset.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEP; i++) push(32'(i * 4), 1'b1, 3'd2, $urandom);
      run_queue(d, 0);
    end
    do_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEP; i++) push(32'(i * 4), 1'b0, 3'd2, 32'h0);
      run_queue(d, 10);
    end

    // WAIT_STATES=0 back-to-back write then read.
    push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push(32'h10, 1'b0, 3'd2, 32'h0);
    run_queue(0, 0);
    chk_eq("raw_deadbeef", last_rdata, 32'hDEADBEEF);

    // WAIT_STATES=2 single read.
    push(32'h20, 1'b0, 3'd2, 32'h0);
    run_queue(1, 0);

    // Byte and half-word merges into a cleared word, on every DUT.
    for (int d = 0; d < NDUT; d++) begin
      push(32'h30, 1'b1, 3'd2, 32'h00000000);
      push(32'h31, 1'b1, 3'd0, 32'h0000AA00);
      push(32'h32, 1'b1, 3'd1, 32'h55550000);
      push(32'h30, 1'b0, 3'd2, 32'h0);
      run_queue(d, 0);
      chk_eq("byte_half_merge", last_rdata, 32'h5555AA00);
    end

    // No accept: BUSY with select, then NONSEQ while the bus is stalled elsewhere.
    for (int k = 0; k < 2; k++) begin
      force_low[1] = (k == 1);
      sel[1]   = 1'b1;
      trans[1] = (k == 0) ? 2'b01 : 2'b10;
      addr[1]  = 32'h20;
      wr[1]    = 1'b1;
      size[1]  = 3'd2;
      wdata[1] = 32'hBADC0FFE;
      repeat (3) begin
        @(negedge H_clk);
        chk_eq("no_accept_ready", {31'h0, ready_o[1]}, 32'h1);
        chk_eq("no_accept_rdata", rdata[1], 32'h0);
        @(posedge H_clk);
        #1;
      end
      drive_idle(1);
      force_low[1] = 1'b0;
    end
    push(32'h20, 1'b0, 3'd2, 32'h0);
    run_queue(1, 0);

    // WAIT_STATES=3: reset in the second wait cycle of a write discards it.
    sel[2]   = 1'b1;
    trans[2] = 2'b10;
    addr[2]  = 32'h40;
    wr[2]    = 1'b1;
    size[2]  = 3'd2;
    @(posedge H_clk);
    #1;
    drive_idle(2);
    wdata[2] = 32'h12345678;
    @(negedge H_clk);
    chk_eq("rst_wait1_ready", {31'h0, ready_o[2]}, 32'h0);
    @(posedge H_clk);
    #1;
    H_rst = 1'b1;
    @(negedge H_clk);
    chk_eq("rst_wait2_ready", {31'h0, ready_o[2]}, 32'h0);
    @(posedge H_clk);
    #1;
    H_rst = 1'b0;
    @(negedge H_clk);
    chk_eq("after_rst_ready", {31'h0, ready_o[2]}, 32'h1);
    chk_eq("after_rst_rdata", rdata[2], 32'h0);
    @(posedge H_clk);
    #1;
    wdata[2] = 32'h0;
    push(32'h40, 1'b0, 3'd2, 32'h0);
    run_queue(2, 0);

    // Randomized mixed traffic with full 32-bit addresses (aliasing) and all sizes.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 60; i++) begin
        push($urandom, 1'($urandom % 2), 3'($urandom % 8), $urandom);
      end
      run_queue(d, 25);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
